// File: rtl/axi_regarray_pkg.sv
// Shared types and helpers for the parametrised AXI4-Lite register array.
package axi_regarray_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Upper bound on register count; mode masks are sized to this.
    localparam int unsigned MAX_REGS = 256;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic [1:0] {MODE_RW, MODE_RO, MODE_W1C} reg_mode_t;

    // RO takes precedence over W1C when both mask bits are set.
    function automatic reg_mode_t mode_of(
        input logic [7:0]          idx,
        input logic [MAX_REGS-1:0] ro_mask,
        input logic [MAX_REGS-1:0] w1c_mask
    );
        if (ro_mask[idx]) begin
            return MODE_RO;
        end else if (w1c_mask[idx]) begin
            return MODE_W1C;
        end
        return MODE_RW;
    endfunction

endpackage

// File: rtl/regarray_cell.sv
// One register of the array: RW (byte-strobed replace), RO (tracks hw_in)
// or W1C (write-1-to-clear, hardware set wins over a same-cycle clear).
module regarray_cell
    import axi_regarray_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter reg_mode_t   MODE = MODE_RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   hw_in,
    input  logic [DW-1:0]   hw_set,
    output logic [DW-1:0]   q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] byte_mask;

    // Next-state value according to the register mode.
    always_comb begin
        byte_mask = '0;
        for (int unsigned b = 0; b < DW/8; b++) begin
            byte_mask[b*8 +: 8] = {8{wstrb[b] & wr_en}};
        end
        q_d = (q_q & ~byte_mask) | (wdata & byte_mask);
        if (MODE == MODE_RO) begin
            q_d = hw_in;
        end else if (MODE == MODE_W1C) begin
            q_d = (q_q & ~(wdata & byte_mask)) | hw_set;
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/axi_register_array_v2.sv
// AXI4-Lite slave register file with per-register RW/RO/W1C modes,
// byte strobes, independent AW/W acceptance, SLVERR on out-of-range
// addresses and per-register write pulses.
module axi_register_array_v2
    import axi_regarray_pkg::*;
#(
    parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned         C_NUM_REGS         = 16,
    parameter int unsigned         C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [MAX_REGS-1:0] C_RO_MASK          = '0,
    parameter logic [MAX_REGS-1:0] C_W1C_MASK         = '0
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
    output logic [C_NUM_REGS-1:0]                    wr_pulse
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned ADDR_LSB = $clog2(SW);
    localparam int unsigned IDXW     = AW - ADDR_LSB;

    // Write channel state
    wr_state_t               wr_state_q;
    logic                    aw_have_q;
    logic                    w_have_q;
    logic [IDXW-1:0]         aw_idx_q;
    logic [DW-1:0]           wdata_q;
    logic [SW-1:0]           wstrb_q;
    logic                    awready_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic [C_NUM_REGS-1:0]   wr_pulse_q;

    // Read channel state
    rd_state_t               rd_state_q;
    logic                    arready_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DW-1:0]           rdata_q;

    logic                    wr_commit;
    logic                    wr_in_range;
    logic [C_NUM_REGS-1:0]   wr_en_vec;
    logic [IDXW-1:0]         rd_idx;
    logic                    rd_in_range;
    logic [DW-1:0]           rd_sel;
    logic [DW-1:0]           cell_q [C_NUM_REGS];

    logic                    unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Register cells, one per index, mode fixed at elaboration.
    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_cell
        regarray_cell #(
            .DW   (DW),
            .MODE (mode_of(8'(g), C_RO_MASK, C_W1C_MASK))
        ) u_cell (
            .clk    (ACLK),
            .rst    (ARESET),
            .wr_en  (wr_en_vec[g]),
            .wdata  (wdata_q),
            .wstrb  (wstrb_q),
            .hw_in  (hw_in[g*DW +: DW]),
            .hw_set (hw_set[g*DW +: DW]),
            .q      (cell_q[g])
        );
        assign reg_out[g*DW +: DW] = cell_q[g];
    end

    // Commit decode: fires once both beats are latched while idle.
    always_comb begin
        wr_commit   = (wr_state_q == W_IDLE) && aw_have_q && w_have_q;
        wr_in_range = 32'(aw_idx_q) < C_NUM_REGS;
        wr_en_vec   = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            wr_en_vec[i] = wr_commit && wr_in_range && (aw_idx_q == IDXW'(i));
        end
    end

    // Read mux on the live AR address; register values are pre-commit.
    always_comb begin
        rd_idx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
        rd_in_range = 32'(rd_idx) < C_NUM_REGS;
        rd_sel      = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (rd_idx == IDXW'(i)) begin
                rd_sel = cell_q[i];
            end
        end
    end

    // Write channel FSM: independent AW/W latching, commit, then B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            case (wr_state_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID && awready_q) begin
                        aw_have_q <= 1'b1;
                        aw_idx_q  <= S_AXI_AWADDR[AW-1:ADDR_LSB];
                        awready_q <= 1'b0;
                    end else begin
                        awready_q <= !aw_have_q;
                    end
                    if (S_AXI_WVALID && wready_q) begin
                        w_have_q <= 1'b1;
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                        wready_q <= 1'b0;
                    end else begin
                        wready_q <= !w_have_q;
                    end
                    if (wr_commit) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        wr_pulse_q <= wr_en_vec;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        aw_have_q  <= 1'b0;
                        w_have_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: capture on AR handshake, hold until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_in_range ? rd_sel : '0;
                        rresp_q    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_register_array_v2.sv
// Randomised bench for axi_register_array_v2 with a transaction-level
// reference model of the register contents.
`timescale 1ns/1ps
module tb_axi_register_array_v2;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned AW = 8;
    localparam logic [255:0] RO_M  = 256'h20;   // reg5 RO
    localparam logic [255:0] W1C_M = 256'h228;  // reg3, reg9 W1C; reg5 also set, RO wins

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] hw_in = '0, hw_set = '0;
    logic [NR-1:0]   wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pcnt[NR];
    logic [31:0] m[NR];

    axi_register_array_v2 #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_NUM_REGS         (NR),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_RO_MASK          (RO_M),
        .C_W1C_MASK         (W1C_M)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .hw_in         (hw_in),
        .hw_set        (hw_set),
        .wr_pulse      (wr_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of each write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pcnt[i]++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) check_eq(tag, reg_out[i*32 +: 32], m[i]);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int aw_cyc, w_cyc, bv_cyc, last, idx, tot_b, tot_a;
        int pb[NR];
        logic [1:0] resp;
        bit inr;
        idx = int'(addr[7:2]);
        inr = idx < NR;
        pb = pcnt;
        aw_cyc = -100; w_cyc = -100; bv_cyc = -1;
        fork
            begin
                @(negedge clk);
                repeat (aw_dly) @(negedge clk);
                awaddr = addr; awvalid = 1'b1;
                for (int n = 0; n <= 40; n++) begin
                    if (awready) begin aw_cyc = cyc; @(negedge clk); break; end
                    if (n == 40) check_eq("aw_timeout", 0, 1);
                    else @(negedge clk);
                end
                awvalid = 1'b0;
            end
            begin
                @(negedge clk);
                repeat (w_dly) @(negedge clk);
                wdata = data; wstrb = strb; wvalid = 1'b1;
                for (int n = 0; n <= 40; n++) begin
                    if (wready) begin w_cyc = cyc; @(negedge clk); break; end
                    if (n == 40) check_eq("w_timeout", 0, 1);
                    else @(negedge clk);
                end
                wvalid = 1'b0;
            end
        join
        for (int n = 0; n <= 40; n++) begin
            if (bvalid) begin bv_cyc = cyc; break; end
            if (n == 40) check_eq("b_timeout", 0, 1);
            else @(negedge clk);
        end
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        check_eq("b_latency", bv_cyc, last + 2);
        resp = bresp;
        check_eq("bresp", {30'd0, resp}, inr ? 32'd0 : 32'd2);
        repeat (b_dly) begin
            @(negedge clk);
            check_eq("b_hold_valid", {31'd0, bvalid}, 1);
            check_eq("b_hold_awready", {31'd0, awready}, 0);
            check_eq("b_hold_resp", {30'd0, bresp}, {30'd0, resp});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("b_drop", {31'd0, bvalid}, 0);
        if (inr && !RO_M[idx]) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    if (W1C_M[idx]) m[idx][b*8 +: 8] = m[idx][b*8 +: 8] & ~data[b*8 +: 8];
                    else m[idx][b*8 +: 8] = data[b*8 +: 8];
                end
            end
        end
        tot_b = 0; tot_a = 0;
        for (int i = 0; i < NR; i++) begin tot_b += pb[i]; tot_a += pcnt[i]; end
        check_eq("pulse_total", tot_a - tot_b, inr ? 1 : 0);
        if (inr) check_eq("pulse_idx", pcnt[idx] - pb[idx], 1);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly);
        int ar_cyc, idx;
        logic [31:0] exp_d, got_d;
        logic [1:0] got_r;
        bit inr;
        idx = int'(addr[7:2]);
        inr = idx < NR;
        exp_d = inr ? m[idx] : 32'd0;
        ar_cyc = -100;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            if (arready) begin ar_cyc = cyc; @(negedge clk); break; end
            if (n == 40) check_eq("ar_timeout", 0, 1);
            else @(negedge clk);
        end
        arvalid = 1'b0;
        check_eq("r_latency_valid", {31'd0, rvalid}, 1);
        check_eq("r_latency_cyc", cyc, ar_cyc + 1);
        got_d = rdata; got_r = rresp;
        repeat (r_dly) begin
            @(negedge clk);
            check_eq("r_hold_valid", {31'd0, rvalid}, 1);
            check_eq("r_hold_data", rdata, got_d);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_eq("r_drop", {31'd0, rvalid}, 0);
        check_eq("rdata", got_d, exp_d);
        check_eq("rresp", {30'd0, got_r}, inr ? 32'd0 : 32'd2);
    endtask

    task automatic hw_set_pulse(input int idx, input logic [31:0] val);
        @(negedge clk);
        hw_set[idx*32 +: 32] = val;
        @(negedge clk);
        hw_set = '0;
        if (W1C_M[idx] && !RO_M[idx]) m[idx] = m[idx] | val;
    endtask

    task automatic set_hw_in(input logic [31:0] val);
        @(negedge clk);
        for (int i = 0; i < NR; i++) hw_in[i*32 +: 32] = $urandom;
        hw_in[5*32 +: 32] = val;
        @(negedge clk);
        @(negedge clk);
        m[5] = val;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin m[i] = '0; pcnt[i] = 0; end
        hw_in[5*32 +: 32] = 32'hA5A5_0005;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_awready", {31'd0, awready}, 0);
        check_eq("rst_wready", {31'd0, wready}, 0);
        check_eq("rst_arready", {31'd0, arready}, 0);
        check_eq("rst_bvalid", {31'd0, bvalid}, 0);
        check_eq("rst_rvalid", {31'd0, rvalid}, 0);
        check_eq("rst_resp", {28'd0, bresp, rresp}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_pulse", {16'd0, wr_pulse}, 0);
        check_regs("rst_reg");
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_awready", {31'd0, awready}, 1);
        check_eq("post_rst_arready", {31'd0, arready}, 1);
        m[5] = 32'hA5A5_0005;

        // Basic RW writes and read-back
        for (int i = 0; i < 4; i++) axi_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(8'(i*4), i);
        check_regs("basic_reg");

        // W ahead of AW by three cycles
        axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
        axi_read(8'h08, 0);
        // AW ahead of W
        axi_write(8'h1C, 32'h1234_5678, 4'hF, 0, 2, 1);

        // Byte strobe
        axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(8'h04, 32'h0000_0000, 4'b0010, 1, 1, 0);
        check_eq("strobe_reg1", reg_out[1*32 +: 32], 32'hFFFF_00FF);
        axi_read(8'h04, 0);

        // W1C behaviour on reg3
        hw_set_pulse(3, 32'hF0);
        axi_read(8'h0C, 0);
        axi_write(8'h0C, 32'h30, 4'hF, 0, 0, 0);
        axi_read(8'h0C, 1);
        fork
            axi_write(8'h0C, 32'h10, 4'hF, 0, 0, 0);
            begin
                @(negedge clk); @(negedge clk);
                hw_set[3*32 +: 32] = 32'h10;
                @(negedge clk);
                hw_set = '0;
            end
        join
        m[3] = m[3] | 32'h10;
        check_eq("w1c_collision", reg_out[3*32 +: 32], 32'hD0);
        axi_read(8'h0C, 0);

        // hw_set ignored on RW/RO lanes, writes ignored on RO
        hw_set_pulse(0, 32'hFFFF_0000);
        hw_set_pulse(5, 32'hFFFF_FFFF);
        axi_write(8'h14, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
        axi_read(8'h14, 0);
        axi_read(8'h00, 0);

        // Out of range
        axi_write(8'h40, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        axi_read(8'h40, 0);
        check_regs("oor_reg");

        // Randomised traffic
        for (int it = 0; it < 120; it++) begin
            int op;
            logic [7:0] a;
            op = $urandom_range(0, 5);
            a = 8'($urandom_range(0, 8'h5F));
            case (op)
                0, 1: axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                2, 3: axi_read(a, $urandom_range(0, 3));
                4:    hw_set_pulse($urandom_range(0, NR-1), $urandom);
                default: set_hw_in($urandom);
            endcase
        end
        check_regs("rand_reg");

        // BREADY held low, then reset while the response is pending
        @(negedge clk);
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check_eq("hold_bvalid_first", {31'd0, bvalid}, 1);
        awaddr = 8'h04; awvalid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_bvalid", {31'd0, bvalid}, 1);
            check_eq("hold_awready", {31'd0, awready}, 0);
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) m[i] = '0;
        check_eq("async_bvalid", {31'd0, bvalid}, 0);
        check_regs("async_reg");
        awvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m[5] = hw_in[5*32 +: 32];
        check_regs("after_rst_reg");
        axi_write(8'h24, 32'h0000_FFFF, 4'hF, 0, 1, 0);
        axi_read(8'h24, 0);
        axi_read(8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
